uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered transmit stage between a byte producer (UART receiver or any byte source) and `async_transmitter`. Bytes arrive as single-cycle valid strobes, queue in a synchronous FIFO, and an output FSM launches them one at a time as `txd_start` pulses, pacing itself on `txd_busy`. Back-to-back input bursts, such as receiver output at full baud or response strings from a hash core, are absorbed without loss up to `DEPTH`. Overflow is reported through a sticky flag.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.
- `ADDR_W`, $clog2(DEPTH): pointer width; derived, do not override.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `wr_valid`  in  1: one-cycle strobe; `wr_data` is valid this cycle.
- `wr_data`  in  8: byte to enqueue.
- `txd_busy`  in  1: transmitter busy; rises the cycle after `txd_start`.
- `txd_start`  out  1: one-cycle launch pulse to the transmitter.
- `txd_data`  out  8: byte being launched; held until the next launch.
- `count`  out  ADDR_W+1: current occupancy, 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `overflow`  out  1: sticky; set when a write is dropped; cleared only by reset.

## Operation
- Storage: DEPTH×8 array with `wr_ptr` and `rd_ptr` of ADDR_W bits, wrapping naturally modulo DEPTH. A registered `count` is the single source of truth for `full` and `empty`.
- Push: `wr_valid && (!full || pop)`. Writes to `mem[wr_ptr]`, then increments `wr_ptr`.
- Drop: `wr_valid && full && !pop`. The array and pointers are untouched and `overflow` is set to 1.
- Pop: issued only by the FSM in IDLE. It reads `mem[rd_ptr]` into `txd_data` and increments `rd_ptr`.
- Count update: `+1` on push only, `-1` on pop only, unchanged on push+pop or on neither.
- Output FSM states: IDLE, LAUNCH, HOLD.
  - IDLE: if `!empty && !txd_busy`, pop, set `txd_start = 1`, and go to LAUNCH. Otherwise stay.
  - LAUNCH: `txd_start = 0`; unconditionally go to HOLD. This guard cycle covers the one-cycle delay before `txd_busy` rises.
  - HOLD: go to IDLE when `!txd_busy`.
- Bytes are transmitted in write order with no duplication or reordering.
- A write to an empty FIFO is never bypassed. The byte must be stored first, then popped.

## Timing
- All outputs are registered.
- Reset values: `txd_start = 0`, `txd_data = 0x00`, `count = 0`, `empty = 1`, `full = 0`, `overflow = 0`. Also FSM = IDLE and both pointers = 0.
- Latency: `wr_valid` at edge N into an empty, idle FIFO gives `txd_start` high for the cycle after edge N+1, i.e. 2 cycles.
- `txd_start` is exactly one cycle wide. Consecutive launches are at least 3 cycles apart, plus the transmitter busy time.
- `txd_data` changes only on the same edge that raises `txd_start`.
- Simultaneous push and pop while full: the write is accepted, `count` stays at DEPTH, and `overflow` is not set.
- Simultaneous push and pop at `count == 1`: `count` stays 1.
- Pointer wrap-around: `DEPTH-1 → 0` with no special case.
- Reset mid-transmission: the FIFO is flushed and `txd_start` is forced low. The byte already in the transmitter completes on its own, and the FSM restarts in IDLE. After reset the FSM still waits for `!txd_busy` before the next launch.
- `txd_busy` held high indefinitely: the FSM stays in HOLD or IDLE and the FIFO fills. Drops then follow the drop rule above.

## Structure
- Sub-module `sync_fifo_8`: array, pointers, count, full/empty, with push/pop ports. The FSM and overflow logic live in `uart_tx_fifo`.
- Shared constants file: `UART_DATA_W = 8`. FSM state encodings are local to the block.

## Test plan
- Single byte: reset, then `wr_valid` with `0xA5` and `txd_busy` low. Required: `txd_start` pulses 2 cycles later with `txd_data = 0xA5`; `count` goes 0 → 1 → 0.
- Burst ordering: write `0x00..0x0F` on consecutive cycles with a transmitter model (busy for 10 cycles). Required: exactly 16 launches in order and `overflow = 0`.
- Overflow: hold `txd_busy = 1` and write 17 bytes `0x10..0x20`. Required: `full = 1` after 16 writes, `overflow = 1` after the 17th, and on release bytes `0x10..0x1F` are sent with `0x20` absent.
- Push+pop while full: with the FIFO full and the FSM in IDLE, release busy and write `0x55` on the pop cycle. Required: `count` stays 16, `overflow = 0`, and `0x55` is sent last.
- Wrap-around: push and drain 40 bytes in groups of 5. Required: all 40 are sent in order and the pointers have wrapped at least twice.
- Reset mid-operation: with 8 bytes queued and HOLD active, assert reset for 1 cycle. Required: `count = 0`, `empty = 1`, `txd_start = 0`, and no further launches until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared constants for the buffered UART transmit stage
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte-producer / transmitter handshake and FIFO status bundle
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) ();

  logic                   wr_valid;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   txd_busy;
  logic                   txd_start;
  logic [UART_DATA_W-1:0] txd_data;
  logic [ADDR_W:0]        count;
  logic                   empty;
  logic                   full;
  logic                   overflow;

  modport master (
    output wr_valid, wr_data, txd_busy,
    input  txd_start, txd_data, count, empty, full, overflow
  );

  modport slave (
    input  wr_valid, wr_data, txd_busy,
    output txd_start, txd_data, count, empty, full, overflow
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo_8.sv
// rtl/uart_tx_fifo_sync_fifo_8.sv - byte-wide synchronous FIFO with registered count/full/empty
module sync_fifo_8
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [UART_DATA_W-1:0] push_data_i,
  input  logic                   pop_i,
  output logic [UART_DATA_W-1:0] pop_data_o,
  output logic [ADDR_W:0]        count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   empty_q, full_q;

  // Head entry is read combinationally so a pop can hand it to the launch register this cycle.
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == (ADDR_W+1)'(DEPTH));
    end
  end

  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - queues strobed bytes and launches them one at a time to async_transmitter
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_fifo_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   txd_start_q, txd_start_d;
  logic [UART_DATA_W-1:0] txd_data_q, txd_data_d;
  logic                   overflow_q, overflow_d;

  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [UART_DATA_W-1:0] fifo_head;
  logic [ADDR_W:0]        fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign push = bus.wr_valid && (!fifo_full || pop);
  assign drop = bus.wr_valid && fifo_full && !pop;

  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus.wr_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    txd_start_d = 1'b0;
    txd_data_d  = txd_data_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !bus.txd_busy) begin
          pop         = 1'b1;
          txd_start_d = 1'b1;
          txd_data_d  = fifo_head;
          state_d     = ST_LAUNCH;
        end
      end
      // Guard cycle: the transmitter raises busy one cycle after it sees start.
      ST_LAUNCH: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!bus.txd_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      txd_start_q <= 1'b0;
      txd_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      txd_start_q <= txd_start_d;
      txd_data_q  <= txd_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.txd_start = txd_start_q;
  assign bus.txd_data  = txd_data_q;
  assign bus.count     = fifo_count;
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: a byte queue plus the launch pacing rule (launch needs a non-busy cycle
  // at least two cycles after the previous launch, then a non-busy launch cycle).
  byte unsigned mq[$];
  logic         m_released;
  int           m_age;
  logic         m_ovf;
  logic         m_start;
  logic [7:0]   m_data;

  byte unsigned sent[$];
  int   busy_cnt = 0;
  int   busy_len = 10;
  logic force_busy = 1'b0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       exp_start;
    logic [7:0] exp_data;
    int         exp_count;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_released = 1'b1;
    m_age      = 0;
    m_ovf      = 1'b0;
    m_start    = 1'b0;
    m_data     = 8'h00;
  endtask

  task automatic update_tx(input logic s);
    if (s) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus.txd_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic check_outputs();
    chk("txd_start", bus.txd_start, m_start);
    chk("txd_data", bus.txd_data, m_data);
    chk("count", bus.count, mq.size());
    chk("empty", bus.empty, mq.size() == 0);
    chk("full", bus.full, mq.size() == DEPTH);
    chk("overflow", bus.overflow, m_ovf);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    logic s, pop, push, drop;
    bus.wr_valid = v;
    bus.wr_data  = d;
    s    = bus.txd_start;
    pop  = m_released && (mq.size() > 0) && !bus.txd_busy;
    push = v && ((mq.size() < DEPTH) || pop);
    drop = v && (mq.size() == DEPTH) && !pop;
    m_start = 1'b0;
    if (pop) begin
      m_data     = mq.pop_front();
      m_start    = 1'b1;
      m_released = 1'b0;
      m_age      = 0;
    end else begin
      m_age++;
      if (!m_released && m_age >= 2 && !bus.txd_busy) m_released = 1'b1;
    end
    if (push) mq.push_back(d);
    if (drop) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    update_tx(s);
    if (bus.txd_start) sent.push_back(bus.txd_data);
    check_outputs();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    logic s;
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      s = bus.txd_start;
      @(posedge clk);
      #1;
      update_tx(s);
    end
    reset = 1'b0;
    model_reset();
    check_outputs();
  endtask

  task automatic set_force(input logic f);
    force_busy   = f;
    bus.txd_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((mq.size() > 0 || !m_released || busy_cnt > 0) && n < max_cycles) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", mq.size(), 0);
  endtask

  vec_t vecs[4];

  initial begin
    int n_before;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.txd_busy = 1'b0;
    reset        = 1'b1;
    model_reset();
    do_reset(2);

    // Single byte: two-cycle launch latency, count 0 -> 1 -> 0.
    busy_len = 10;
    vecs[0] = '{v: 1'b1, d: 8'hA5, exp_start: 1'b0, exp_data: 8'h00, exp_count: 1};
    vecs[1] = '{v: 1'b0, d: 8'h00, exp_start: 1'b1, exp_data: 8'hA5, exp_count: 0};
    vecs[2] = '{v: 1'b0, d: 8'h00, exp_start: 1'b0, exp_data: 8'hA5, exp_count: 0};
    vecs[3] = '{v: 1'b0, d: 8'h00, exp_start: 1'b0, exp_data: 8'hA5, exp_count: 0};
    for (int i = 0; i < 4; i++) begin
      cycle(vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_start", i), bus.txd_start, vecs[i].exp_start);
      chk($sformatf("vec%0d_data", i), bus.txd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
    end
    drain(200);

    // Burst ordering.
    sent.delete();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i));
    drain(600);
    chk("burst_len", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("burst_order", sent[i], i);
    chk("burst_ovf", bus.overflow, 0);

    // Overflow with the transmitter stuck busy.
    do_reset(1);
    sent.delete();
    set_force(1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i));
    chk("ovf_full", bus.full, 1);
    chk("ovf_pre", bus.overflow, 0);
    cycle(1'b1, 8'h20);
    chk("ovf_set", bus.overflow, 1);
    set_force(1'b0);
    drain(800);
    chk("ovf_len", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("ovf_order", sent[i], 8'h10 + i);

    // Simultaneous push and pop while full.
    do_reset(1);
    sent.delete();
    set_force(1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h30 + i));
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    busy_cnt = 0;
    set_force(1'b0);
    cycle(1'b1, 8'h55);
    chk("pp_start", bus.txd_start, 1);
    chk("pp_count", bus.count, 16);
    chk("pp_ovf", bus.overflow, 0);
    drain(800);
    chk("pp_len", sent.size(), 17);
    if (sent.size() > 0) chk("pp_last", sent[sent.size()-1], 8'h55);

    // Wrap-around: 40 bytes in groups of 5.
    do_reset(1);
    sent.delete();
    busy_len = 3;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'h80 + g*5 + k));
      drain(200);
    end
    chk("wrap_len", sent.size(), 40);
    for (int i = 0; i < 40 && i < sent.size(); i++) chk("wrap_order", sent[i], 8'h80 + i);

    // Reset while HOLD is active with 8 bytes queued.
    busy_len = 10;
    drain(100);
    sent.delete();
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'hC0 + i));
    chk("rst_queued", bus.count, 8);
    chk("rst_launched", sent.size(), 1);
    do_reset(1);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_start", bus.txd_start, 0);
    n_before = sent.size();
    for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00);
    chk("rst_no_launch", sent.size(), n_before);
    cycle(1'b1, 8'hEE);
    drain(100);
    chk("rst_resume", sent.size(), n_before + 1);

    // Randomized traffic against the reference model.
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) busy_len = $urandom_range(0, 8);
      if (i % 150 == 40) set_force(1'b1);
      if (i % 150 == 90) set_force(1'b0);
      cycle($urandom_range(0, 2) == 0, 8'($urandom));
    end
    set_force(1'b0);
    drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
